hazard_stall_controller: RTL and testbench

- Sequences the IF/ID pipeline register and the PC in the 5-stage MIPS pipeline.
- Generates the write enable `ifIdWr`, a PC write enable, an IF/ID flush and an ID/EX bubble.
- Covers three cases: load-use hazards, taken branches resolved in EX, and the multi-cycle multiply/divide unit.
- Sits beside the ID stage. It reads decoded ID fields and EX-stage status, and drives the enables of the IF/ID register, the PC and the ID/EX register.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/md_busy_timer.sv | 58 +++++
 rtl/hazard_stall_controller.sv | 82 ++++++++
 tb/tb_hazard_stall_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the mult/div occupancy state encoding.
package pipeline_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MD_CNT_W = 5;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks HI/LO unit occupancy: busy for MD_CYCLES-1 cycles after a start.
module md_busy_timer
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    md_state_e             r_state;
    md_state_e             w_state_nxt;
    logic [MD_CNT_W-1:0]   r_md_cnt;
    logic [MD_CNT_W-1:0]   w_md_cnt_nxt;
    logic                  r_busy;

    // State, down-counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            r_busy   <= (w_state_nxt == MD_BUSY);
        end
    end

    // Next state: load on issue, count down, return to RUN after the count of 1.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            RUN: begin
                if (start) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = MD_CNT_W'(MD_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
                if (r_md_cnt == MD_CNT_W'(1)) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

    assign busy = r_busy;

endmodule

// File: rtl/hazard_stall_controller.sv
// IF/ID and PC sequencing for load-use, taken-branch and mult/div hazards.
module hazard_stall_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             idIsMulDiv,
    input  logic             idUsesHiLo,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             exBranchTaken,
    output logic             pcWr,
    output logic             ifIdWr,
    output logic             ifIdFlush,
    output logic             idExBubble,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCycles
);

    logic             w_load_use;
    logic             w_md_hazard;
    logic             w_md_start;
    logic             w_md_busy;
    logic [CNT_W-1:0] r_stall_cycles;

    // Hazard detection against the EX load destination and the busy HI/LO unit.
    always_comb begin
        w_load_use  = exMemRead && (exRt != REG_ZERO) &&
                      ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
        w_md_hazard = w_md_busy && idUsesHiLo;
        w_md_start  = idIsMulDiv && !rst && !exBranchTaken && !w_load_use && !w_md_hazard;
    end

    // Output priority: reset, branch flush, stall, normal advance.
    always_comb begin
        pcWr       = 1'b1;
        ifIdWr     = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        if (rst) begin
            pcWr       = 1'b0;
            ifIdWr     = 1'b0;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (exBranchTaken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (w_load_use || w_md_hazard) begin
            pcWr       = 1'b0;
            ifIdWr     = 1'b0;
            idExBubble = 1'b1;
        end
    end

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_md_start),
        .busy  (w_md_busy)
    );

    // Saturating count of cycles in which IF/ID was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!ifIdWr && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign mdBusy      = w_md_busy;
    assign stallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller.
module tb_hazard_stall_controller;

    localparam int unsigned MD_CYCLES = 8;

    logic        clk;
    logic        rst;
    logic [4:0]  idRs, idRt, exRt;
    logic        idUsesRt, idIsMulDiv, idUsesHiLo, exMemRead, exBranchTaken;
    logic        pcWr, ifIdWr, ifIdFlush, idExBubble, mdBusy;
    logic [15:0] stallCycles;

    logic        d2_rst;
    logic [4:0]  d2_idRs, d2_exRt;
    logic        d2_exMemRead;
    logic        d2_pcWr, d2_ifIdWr, d2_ifIdFlush, d2_idExBubble, d2_mdBusy;
    logic [3:0]  d2_stallCycles;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        flush;
        logic        bubble;
        logic        busy;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];

    int m_left  = 0;
    int m_stall = 0;

    hazard_stall_controller #(.MD_CYCLES(MD_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .idIsMulDiv(idIsMulDiv), .idUsesHiLo(idUsesHiLo), .exMemRead(exMemRead),
        .exRt(exRt), .exBranchTaken(exBranchTaken), .pcWr(pcWr), .ifIdWr(ifIdWr),
        .ifIdFlush(ifIdFlush), .idExBubble(idExBubble), .mdBusy(mdBusy),
        .stallCycles(stallCycles)
    );

    hazard_stall_controller #(.MD_CYCLES(MD_CYCLES), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(d2_rst), .idRs(d2_idRs), .idRt(5'd0), .idUsesRt(1'b0),
        .idIsMulDiv(1'b0), .idUsesHiLo(1'b0), .exMemRead(d2_exMemRead),
        .exRt(d2_exRt), .exBranchTaken(1'b0), .pcWr(d2_pcWr), .ifIdWr(d2_ifIdWr),
        .ifIdFlush(d2_ifIdFlush), .idExBubble(d2_idExBubble), .mdBusy(d2_mdBusy),
        .stallCycles(d2_stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected response, advance the model.
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic imd, input logic uhl,
                        input logic mr, input logic [4:0] ert, input logic br);
        exp_t e;
        logic lu, mh, st;
        rst = r; idRs = rs; idRt = rt; idUsesRt = urt; idIsMulDiv = imd;
        idUsesHiLo = uhl; exMemRead = mr; exRt = ert; exBranchTaken = br;
        lu = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        mh = (m_left > 0) && uhl;
        if (r)             begin e.pc = 0; e.ifid = 0; e.flush = 1; e.bubble = 1; end
        else if (br)       begin e.pc = 1; e.ifid = 1; e.flush = 1; e.bubble = 1; end
        else if (lu || mh) begin e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 1; end
        else               begin e.pc = 1; e.ifid = 1; e.flush = 0; e.bubble = 0; end
        e.busy  = (m_left > 0);
        e.stall = 16'(m_stall);
        exp_q.push_back(e);
        st = !r && !br && !lu && !mh && imd && (m_left == 0);
        @(posedge clk);
        if (r) begin
            m_left  = 0;
            m_stall = 0;
        end else begin
            if (!e.ifid && m_stall < 65535) m_stall++;
            if (m_left > 0)  m_left--;
            else if (st)     m_left = MD_CYCLES - 1;
        end
        #1;
    endtask

    // Compare DUT outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pcWr",        32'(pcWr),        32'(e.pc));
            check("ifIdWr",      32'(ifIdWr),      32'(e.ifid));
            check("ifIdFlush",   32'(ifIdFlush),   32'(e.flush));
            check("idExBubble",  32'(idExBubble),  32'(e.bubble));
            check("mdBusy",      32'(mdBusy),      32'(e.busy));
            check("stallCycles", 32'(stallCycles), 32'(e.stall));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; idRs = 0; idRt = 0; idUsesRt = 0; idIsMulDiv = 0; idUsesHiLo = 0;
        exMemRead = 0; exRt = 0; exBranchTaken = 0;
        d2_rst = 1; d2_idRs = 0; d2_exRt = 0; d2_exMemRead = 0;
        @(posedge clk); #1;

        //    rst rs  rt  urt md hl mr exRt br
        step(1, 0,  0,  0,  0, 0, 0, 0,  0);   // reset state
        step(0, 8,  0,  0,  0, 0, 1, 8,  0);   // load-use on rs
        step(0, 0,  0,  0,  0, 0, 0, 0,  0);
        step(0, 0,  0,  1,  0, 0, 1, 0,  0);   // load to $zero
        step(0, 1,  9,  1,  0, 0, 1, 9,  0);   // load-use on rt
        step(0, 1,  9,  0,  0, 0, 1, 9,  0);   // rt not a source
        step(0, 8,  0,  0,  0, 0, 1, 8,  1);   // branch beats stall
        step(0, 0,  0,  0,  1, 1, 0, 0,  0);   // mult issues
        repeat (8) step(0, 0, 0, 0, 0, 1, 0, 0, 0);   // mflo stalled 7, then proceeds
        step(0, 0,  0,  0,  0, 0, 0, 0,  0);
        step(0, 0,  0,  0,  1, 1, 0, 0,  0);   // second mult issues
        step(0, 4,  0,  0,  0, 1, 1, 4,  0);   // load-use and mdHazard together
        repeat (6) step(0, 0, 0, 0, 1, 1, 0, 0, 0);   // back-to-back mult stalled
        step(0, 0,  0,  0,  1, 1, 0, 0,  0);   // mult issues first RUN cycle
        step(0, 0,  0,  0,  0, 1, 0, 0,  0);
        step(0, 0,  0,  0,  0, 1, 0, 0,  1);   // branch does not abort mult
        step(1, 0,  0,  0,  0, 1, 0, 0,  0);   // reset on 3rd busy cycle
        step(0, 0,  0,  0,  0, 1, 0, 0,  0);   // mflo proceeds after reset
        step(0, 0,  0,  0,  0, 0, 0, 0,  0);

        // Saturation on the 4-bit counter instance.
        @(posedge clk); #1;
        d2_rst = 0; d2_exMemRead = 1; d2_exRt = 5'd3; d2_idRs = 5'd3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check("sat_stallCycles", 32'(d2_stallCycles), (k < 15) ? k : 15);
            check("sat_ifIdWr",      32'(d2_ifIdWr),      32'd0);
            check("sat_pcWr",        32'(d2_pcWr),        32'd0);
            check("sat_idExBubble",  32'(d2_idExBubble),  32'd1);
            check("sat_ifIdFlush",   32'(d2_ifIdFlush),   32'd0);
            check("sat_mdBusy",      32'(d2_mdBusy),      32'd0);
        end

        @(negedge clk);
        if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
